load_store_unit: RTL and testbench

Initiator side of the data-memory interface. Sits in the MEM stage between the pipeline and the data memory. Converts MemRead/MemWrite/Funct3/address/store-data into a request–grant–response bus transaction, and generates byte enables and replicated store data. Extracts and sign/zero-extends load data, flags misaligned and illegal accesses, and stalls the pipeline until each access completes.

---
 rtl/load_store_unit_pkg.sv | 31 +++
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit_load_align.sv | 31 +++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: Funct3 codes, FSM states and
// the store-side byte-enable / lane-replication helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} lsu_state_t;

  // Byte enables from access size (Funct3[1:0]) and byte offset.
  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   be_gen = 4'b0001 << off;
      2'b01:   be_gen = off[1] ? 4'b1100 : 4'b0011;
      default: be_gen = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across every lane it may land in.
  function automatic logic [31:0] wdata_rep(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   wdata_rep = {4{wd[7:0]}};
      2'b01:   wdata_rep = {2{wd[15:0]}};
      default: wdata_rep = wd;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/grant/response data-memory bus between the LSU (master) and memory.
interface lsu_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Load formatting: picks the addressed lane of the raw memory word and
// sign- or zero-extends it according to the captured Funct3.
module lsu_load_align import lsu_pkg::*; (
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select followed by extension.
  always_comb begin
    case (offset)
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      F3_B:    load_word = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_word = {24'b0, byte_lane};
      F3_H:    load_word = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_word = {16'b0, half_lane};
      default: load_word = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns pipeline load/store requests into one
// request-grant-response bus transaction at a time and stalls until done.
module load_store_unit import lsu_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              rd_valid,
  output logic              stall,
  output logic              misaligned,
  output logic              illegal,
  lsu_mem_if.master         mem
);

  lsu_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              rd_valid_q, rd_valid_d;

  logic              access, bad_f3, illegal_acc, misal_acc, legal_acc, in_idle;
  logic [DATA_W-1:0] load_word;

  lsu_load_align u_align (
    .mem_rdata (mem.mem_rdata),
    .offset    (off_q),
    .funct3    (f3_q),
    .load_word (load_word)
  );

  // Decode the presented access and derive the combinational status outputs.
  always_comb begin
    access = MemRead | MemWrite;
    bad_f3 = 1'b1;
    if (MemRead) begin
      case (Funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: bad_f3 = 1'b0;
        default:                        bad_f3 = 1'b1;
      endcase
    end else if (MemWrite) begin
      case (Funct3)
        F3_B, F3_H, F3_W: bad_f3 = 1'b0;
        default:          bad_f3 = 1'b1;
      endcase
    end
    illegal_acc = access & ((MemRead & MemWrite) | bad_f3);
    misal_acc   = access & ~illegal_acc &
                  (((Funct3[1:0] == 2'b01) & a[0]) |
                   ((Funct3[1:0] == 2'b10) & (a[1:0] != 2'b00)));
    legal_acc   = access & ~illegal_acc & ~misal_acc;
    in_idle     = (state_q == IDLE);
    // Status is forced low while reset is held, even with an access present.
    stall       = rst_n & ((in_idle & legal_acc) | (state_q == REQ) | (state_q == WAIT_R));
    misaligned  = rst_n & in_idle & misal_acc;
    illegal     = rst_n & in_idle & illegal_acc;
  end

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    rd_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal_acc) begin
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = MemWrite;
          mem_addr_d  = {a[ADDR_W-1:2], 2'b00};
          mem_be_d    = be_gen(Funct3, a[1:0]);
          mem_wdata_d = wdata_rep(Funct3, wd);
          f3_d        = Funct3;
          off_d       = a[1:0];
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? DONE : WAIT_R;
        end
      end
      WAIT_R: begin
        if (mem.mem_rvalid) begin
          rd_d       = load_word;
          rd_valid_d = 1'b1;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0;
      mem_wdata_q <= '0;
      f3_q        <= 3'b0;
      off_q       <= 2'b0;
      rd_q        <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign rd            = rd_q;
  assign rd_valid      = rd_valid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: vector table of loads/stores/faults driven
// against a small memory responder, load results checked via a queue.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic [2:0]        funct3 = 3'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdat = '0;
  logic [DATA_W-1:0] rd;
  logic              rd_valid, stall, misaligned, illegal;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemRead    (mem_read),
    .MemWrite   (mem_write),
    .Funct3     (funct3),
    .a          (addr),
    .wd         (wdat),
    .rd         (rd),
    .rd_valid   (rd_valid),
    .stall      (stall),
    .misaligned (misaligned),
    .illegal    (illegal),
    .mem        (mem_bus.master)
  );

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          gd;      // extra REQ cycles before gnt
    int          rvd;     // extra WAIT_R cycles before rvalid
    int          kind;    // 0 legal, 1 misaligned, 2 illegal
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  n, req_cycles, stall_cnt, rv_cnt, gw, rw;
    bit  granted, rv_sent, done, is_load;
    logic [31:0] exp;
    is_load = v.rd_en && !v.wr_en;
    @(posedge clk); #1;
    mem_read = v.rd_en; mem_write = v.wr_en; funct3 = v.f3; addr = v.a; wdat = v.wd;
    if (v.kind != 0) begin
      @(negedge clk);
      chk($sformatf("v%0d misaligned", idx), {31'b0, misaligned}, {31'b0, v.kind == 1});
      chk($sformatf("v%0d illegal", idx), {31'b0, illegal}, {31'b0, v.kind == 2});
      chk($sformatf("v%0d fault stall", idx), {31'b0, stall}, 32'h0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk($sformatf("v%0d fault mem_req", idx), {31'b0, mem_bus.mem_req}, 32'h0);
      end
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    if (is_load) exp_q.push_back(v.e_rd);
    n = 0; done = 0; granted = 0; rv_sent = 0; gw = 0; rw = 0;
    req_cycles = 0; stall_cnt = 0; rv_cnt = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
      if (n == 0) begin
        chk($sformatf("v%0d first stall", idx), {31'b0, stall}, 32'h1);
        chk($sformatf("v%0d req latency", idx), {31'b0, mem_bus.mem_req}, 32'h0);
      end
      if (stall) stall_cnt++;
      if (rd_valid) begin
        rv_cnt++;
        if (exp_q.size() == 0) chk($sformatf("v%0d unexpected rd_valid", idx), 32'h1, 32'h0);
        else begin
          exp = exp_q.pop_front();
          chk($sformatf("v%0d rd", idx), rd, exp);
        end
      end
      if (mem_bus.mem_req) begin
        req_cycles++;
        chk($sformatf("v%0d mem_addr", idx), mem_bus.mem_addr, v.e_addr);
        chk($sformatf("v%0d mem_be", idx), {28'b0, mem_bus.mem_be}, {28'b0, v.e_be});
        chk($sformatf("v%0d mem_we", idx), {31'b0, mem_bus.mem_we}, {31'b0, v.wr_en});
        if (!is_load) chk($sformatf("v%0d mem_wdata", idx), mem_bus.mem_wdata, v.e_wdata);
      end
      if (granted && is_load && !rv_sent) begin
        if (rw == v.rvd) begin
          mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = v.rdata; rv_sent = 1;
        end else rw++;
      end
      if (mem_bus.mem_req && !granted) begin
        if (gw == v.gd) begin mem_bus.mem_gnt = 1'b1; granted = 1; end
        else gw++;
      end
      if (n > 0 && !stall) done = 1;
      n++;
    end
    if (!done) chk($sformatf("v%0d timeout", idx), 32'h1, 32'h0);
    chk($sformatf("v%0d stall cycles", idx), stall_cnt, is_load ? 3 + v.gd + v.rvd : 2 + v.gd);
    chk($sformatf("v%0d req cycles", idx), req_cycles, v.gd + 1);
    chk($sformatf("v%0d rd_valid pulses", idx), rv_cnt, is_load ? 1 : 0);
    if (is_load) last_rd = v.e_rd;
    chk($sformatf("v%0d rd hold", idx), rd, last_rd);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;

    //           rd wr  f3      a          wd            rdata         gd rvd k  e_addr       e_be     e_wdata       e_rd
    vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h104, 4'b1111, 32'hDEADBEEF, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 3'b000, 32'h10B, 32'h000000A5, 32'h0,        0, 0, 0, 32'h108, 4'b1000, 32'hA5A5A5A5, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 3'b001, 32'h106, 32'h1234CAFE, 32'h0,        0, 0, 0, 32'h104, 4'b1100, 32'hCAFECAFE, 32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3'b000, 32'h200, 32'h0,        32'h80F07F81, 0, 0, 0, 32'h200, 4'b0001, 32'h0,        32'hFFFFFF81});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3'b100, 32'h201, 32'h0,        32'h80F07F81, 0, 0, 0, 32'h200, 4'b0010, 32'h0,        32'h0000007F});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3'b001, 32'h202, 32'h0,        32'h80F07F81, 0, 0, 0, 32'h200, 4'b1100, 32'h0,        32'hFFFF80F0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3'b101, 32'h202, 32'h0,        32'h80F07F81, 0, 0, 0, 32'h200, 4'b1100, 32'h0,        32'h000080F0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h1F0, 32'h0BADF00D, 32'h0,        2, 0, 0, 32'h1F0, 4'b1111, 32'h0BADF00D, 32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3'b000, 32'h203, 32'h0,        32'h80F07F81, 0, 0, 0, 32'h200, 4'b1000, 32'h0,        32'hFFFFFF80});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 32'h300, 32'h0,        32'h12345678, 3, 2, 0, 32'h300, 4'b1111, 32'h0,        32'h12345678});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3'b001, 32'h201, 32'h0,        32'h0,        0, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 3'b001, 32'h103, 32'h0,        32'h0,        0, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 0, 2, 32'h0,   4'b0000, 32'h0,        32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 3'b010, 32'h100, 32'h0,        32'h0,        0, 0, 2, 32'h0,   4'b0000, 32'h0,        32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 0, 2, 32'h0,   4'b0000, 32'h0,        32'h0});

    // Reset state, with a legal load presented while reset is held.
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100;
    @(negedge clk);
    chk("reset stall", {31'b0, stall}, 32'h0);
    chk("reset misaligned", {31'b0, misaligned}, 32'h0);
    chk("reset illegal", {31'b0, illegal}, 32'h0);
    chk("reset mem_req", {31'b0, mem_bus.mem_req}, 32'h0);
    chk("reset mem_we", {31'b0, mem_bus.mem_we}, 32'h0);
    chk("reset mem_addr", mem_bus.mem_addr, 32'h0);
    chk("reset mem_be", {28'b0, mem_bus.mem_be}, 32'h0);
    chk("reset mem_wdata", mem_bus.mem_wdata, 32'h0);
    chk("reset rd", rd, 32'h0);
    chk("reset rd_valid", {31'b0, rd_valid}, 32'h0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset while in REQ: mem_req drops without waiting for a clock.
    @(posedge clk); #1;
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h500; wdat = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    chk("rstreq mem_req before", {31'b0, mem_bus.mem_req}, 32'h1);
    rst_n = 1'b0; #1;
    chk("rstreq mem_req after", {31'b0, mem_bus.mem_req}, 32'h0);
    chk("rstreq stall", {31'b0, stall}, 32'h0);
    mem_write = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset while in WAIT_R, then a stale rvalid must be ignored.
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);                      // IDLE
    @(negedge clk);                      // REQ
    chk("rstwait req", {31'b0, mem_bus.mem_req}, 32'h1);
    mem_bus.mem_gnt = 1'b1;
    @(negedge clk);                      // WAIT_R
    mem_bus.mem_gnt = 1'b0;
    chk("rstwait stall in WAIT_R", {31'b0, stall}, 32'h1);
    rst_n = 1'b0; #1;
    mem_read = 1'b0;
    chk("rstwait stall", {31'b0, stall}, 32'h0);
    chk("rstwait rd cleared", rd, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstwait rd_valid", {31'b0, rd_valid}, 32'h0);
      chk("rstwait rd", rd, 32'h0);
      chk("rstwait mem_req", {31'b0, mem_bus.mem_req}, 32'h0);
    end
    mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;

    chk("scoreboard empty", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
